game_ctrl_sm: RTL and testbench

//  Main state machine for the pong game unit. Sequences the game:

---
 rtl/game_ctrl_sm.sv | 164 ++++++++++++++++
 tb/tb_game_ctrl_sm.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/game_ctrl_sm.sv
// Pong game sequencer: idle/serve/play/pause/point/over, key debounce, scores, ball gating.
// Latency: key or collision event to registered state/output change is 1 clk_25.
// Backpressure: none; the block steps on end_of_frame pulses and per-cycle collision inputs.
module game_ctrl_sm #(
    parameter int WIN_SCORE       = 7,
    parameter int SERVE_FRAMES    = 60,
    parameter int POINT_FRAMES    = 90,
    parameter int DEBOUNCE_FRAMES = 3
) (
    input  logic       clk_25,
    input  logic       resetN,
    input  logic       end_of_frame,
    input  logic [1:0] key,
    input  logic [3:0] frame_collision,
    output logic       ball_enable,
    output logic       ball_reset,
    output logic [2:0] screen,
    output logic [3:0] score_left,
    output logic [3:0] score_right,
    output logic [2:0] game_state
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_SERVE = 3'd1;
    localparam logic [2:0] ST_PLAY  = 3'd2;
    localparam logic [2:0] ST_PAUSE = 3'd3;
    localparam logic [2:0] ST_POINT = 3'd4;
    localparam logic [2:0] ST_OVER  = 3'd5;

    localparam int          DW      = $clog2(DEBOUNCE_FRAMES + 1);
    localparam logic [DW-1:0] DB_MAX = DW'(DEBOUNCE_FRAMES);
    localparam logic [3:0]  WIN     = 4'(WIN_SCORE);
    localparam logic [7:0]  SERVE_LAST = 8'(SERVE_FRAMES - 1);
    localparam logic [7:0]  POINT_LAST = 8'(POINT_FRAMES - 1);

    logic [1:0][DW-1:0] deb_q, deb_d;
    logic [1:0]         press;
    logic [2:0]         state_q, state_d;
    logic [7:0]         timer_q, timer_d;
    logic [3:0]         score_l_q, score_l_d;
    logic [3:0]         score_r_q, score_r_d;
    logic               ball_en_q, ball_en_d;
    logic               ball_rst_q, ball_rst_d;
    logic [2:0]         screen_q, screen_d;
    logic               start_evt, pause_evt, hit_left, hit_right;

    // Per-key debounce: count low frame samples, pulse once when the count saturates.
    always_comb begin
        deb_d = deb_q;
        press = 2'b00;
        for (int k = 0; k < 2; k++) begin
            if (end_of_frame) begin
                if (key[k]) begin
                    deb_d[k] = '0;
                end else if (deb_q[k] < DB_MAX) begin
                    deb_d[k] = deb_q[k] + 1'b1;
                    press[k] = (deb_q[k] == DB_MAX - 1'b1);
                end
            end
        end
    end

    assign start_evt = press[0];
    assign pause_evt = press[1];
    assign hit_left  = frame_collision[2];
    assign hit_right = frame_collision[3];

    // Game sequencing and score update; collisions take priority over pause in PLAY.
    always_comb begin
        state_d   = state_q;
        score_l_d = score_l_q;
        score_r_d = score_r_q;
        case (state_q)
            ST_IDLE: begin
                if (start_evt) begin
                    score_l_d = '0;
                    score_r_d = '0;
                    state_d   = ST_SERVE;
                end
            end
            ST_SERVE: begin
                if (end_of_frame && timer_q == SERVE_LAST) state_d = ST_PLAY;
            end
            ST_PLAY: begin
                if (hit_left && hit_right) begin
                    state_d = ST_SERVE;
                end else if (hit_left) begin
                    if (score_r_q < WIN) score_r_d = score_r_q + 1'b1;
                    state_d = ST_POINT;
                end else if (hit_right) begin
                    if (score_l_q < WIN) score_l_d = score_l_q + 1'b1;
                    state_d = ST_POINT;
                end else if (pause_evt) begin
                    state_d = ST_PAUSE;
                end
            end
            ST_PAUSE: begin
                if (pause_evt) state_d = ST_PLAY;
            end
            ST_POINT: begin
                if (end_of_frame && timer_q == POINT_LAST) begin
                    state_d = (score_l_q == WIN || score_r_q == WIN) ? ST_OVER : ST_SERVE;
                end
            end
            ST_OVER: begin
                if (start_evt) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Frame timer restarts on every state change, otherwise counts frames.
    always_comb begin
        timer_d = timer_q;
        if (state_d != state_q) begin
            timer_d = '0;
        end else if (end_of_frame) begin
            timer_d = timer_q + 1'b1;
        end
    end

    // Output decode from the next state so outputs line up with the state register.
    always_comb begin
        ball_en_d  = (state_d == ST_PLAY);
        ball_rst_d = !(state_d == ST_PLAY || state_d == ST_PAUSE);
        case (state_d)
            ST_SERVE, ST_PLAY, ST_POINT: screen_d = 3'd1;
            ST_PAUSE:                    screen_d = 3'd2;
            ST_OVER:                     screen_d = (score_l_d == WIN) ? 3'd3 : 3'd4;
            default:                     screen_d = 3'd0;
        endcase
    end

    // State, timer, debounce, score and output registers, all async-cleared.
    always_ff @(posedge clk_25 or negedge resetN) begin
        if (!resetN) begin
            deb_q      <= '0;
            state_q    <= ST_IDLE;
            timer_q    <= '0;
            score_l_q  <= '0;
            score_r_q  <= '0;
            ball_en_q  <= 1'b0;
            ball_rst_q <= 1'b1;
            screen_q   <= 3'd0;
        end else begin
            deb_q      <= deb_d;
            state_q    <= state_d;
            timer_q    <= timer_d;
            score_l_q  <= score_l_d;
            score_r_q  <= score_r_d;
            ball_en_q  <= ball_en_d;
            ball_rst_q <= ball_rst_d;
            screen_q   <= screen_d;
        end
    end

    assign ball_enable = ball_en_q;
    assign ball_reset  = ball_rst_q;
    assign screen      = screen_q;
    assign score_left  = score_l_q;
    assign score_right = score_r_q;
    assign game_state  = state_q;

endmodule

// File: tb/tb_game_ctrl_sm.sv
// Directed bench for game_ctrl_sm: reset, serve, scoring, tie, pause debounce, game over, async reset.
// Frames are 2 clocks long; inputs change and outputs are sampled on the falling edge.
// No backpressure involved; every expected value below is hand-derived.
module tb_game_ctrl_sm;

    logic       clk_25;
    logic       resetN;
    logic       end_of_frame;
    logic [1:0] key;
    logic [3:0] frame_collision;
    logic       ball_enable;
    logic       ball_reset;
    logic [2:0] screen;
    logic [3:0] score_left;
    logic [3:0] score_right;
    logic [2:0] game_state;

    int n_vec = 0;
    int n_err = 0;

    game_ctrl_sm dut (
        .clk_25          (clk_25),
        .resetN          (resetN),
        .end_of_frame    (end_of_frame),
        .key             (key),
        .frame_collision (frame_collision),
        .ball_enable     (ball_enable),
        .ball_reset      (ball_reset),
        .screen          (screen),
        .score_left      (score_left),
        .score_right     (score_right),
        .game_state      (game_state)
    );

    initial begin
        clk_25 = 1'b0;
        forever #20 clk_25 = ~clk_25;
    end

    task automatic check_vec(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
        n_vec++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic check_all(input string tag, input int st, input int be, input int br,
                             input int scr, input int sl, input int sr);
        check_vec({tag, ".state"}, 8'(game_state),  8'(st));
        check_vec({tag, ".ben"},   8'(ball_enable), 8'(be));
        check_vec({tag, ".brst"},  8'(ball_reset),  8'(br));
        check_vec({tag, ".scr"},   8'(screen),      8'(scr));
        check_vec({tag, ".sl"},    8'(score_left),  8'(sl));
        check_vec({tag, ".sr"},    8'(score_right), 8'(sr));
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk_25);
            end_of_frame = 1'b1;
            @(negedge clk_25);
            end_of_frame = 1'b0;
        end
    endtask

    task automatic coll(input logic [3:0] c);
        @(negedge clk_25);
        frame_collision = c;
        @(negedge clk_25);
        frame_collision = 4'b0000;
    endtask

    initial begin
        resetN          = 1'b0;
        end_of_frame    = 1'b0;
        key             = 2'b11;
        frame_collision = 4'b0000;
        #50;
        check_all("reset", 0, 0, 1, 0, 0, 0);
        @(negedge clk_25);
        resetN = 1'b1;

        // T1: start debounce and serve countdown
        key[0] = 1'b0;
        frames(2);
        check_vec("t1.idle_2frames", 8'(game_state), 8'd0);
        frames(1);
        check_all("t1.serve", 1, 0, 1, 1, 0, 0);
        key[0] = 1'b1;
        frames(1);
        frames(58);
        check_vec("t1.serve_59", 8'(game_state), 8'd1);
        frames(1);
        check_all("t1.play", 2, 1, 0, 1, 0, 0);

        // T2: left collision scores for right player
        coll(4'b0100);
        check_all("t2.point", 4, 0, 1, 1, 0, 1);
        frames(89);
        check_vec("t2.point_89", 8'(game_state), 8'd4);
        frames(1);
        check_vec("t2.serve", 8'(game_state), 8'd1);
        frames(60);
        check_vec("t2.play", 8'(game_state), 8'd2);

        // T3: simultaneous left/right is a tie; top/bottom ignored
        coll(4'b1100);
        check_all("t3.tie", 1, 0, 1, 1, 0, 1);
        frames(60);
        check_vec("t3.play", 8'(game_state), 8'd2);
        coll(4'b0011);
        check_all("t3.topbot", 2, 1, 0, 1, 0, 1);

        // T4: short press rejected, full press pauses, second press resumes
        key[1] = 1'b0;
        frames(2);
        key[1] = 1'b1;
        frames(1);
        check_vec("t4.short", 8'(game_state), 8'd2);
        key[1] = 1'b0;
        frames(3);
        check_all("t4.pause", 3, 0, 0, 2, 0, 1);
        key[1] = 1'b1;
        frames(1);
        check_vec("t4.hold_pause", 8'(game_state), 8'd3);
        key[1] = 1'b0;
        frames(3);
        check_all("t4.resume", 2, 1, 0, 1, 0, 1);
        key[1] = 1'b1;
        frames(1);

        // T5: right-edge hits drive left player to 7, game over
        for (int i = 0; i < 7; i++) begin
            coll(4'b1000);
            check_vec("t5.sl", 8'(score_left), 8'(i + 1));
            check_vec("t5.point", 8'(game_state), 8'd4);
            frames(90);
            if (i < 6) begin
                check_vec("t5.serve", 8'(game_state), 8'd1);
                frames(60);
                check_vec("t5.play", 8'(game_state), 8'd2);
            end
        end
        check_all("t5.over", 5, 0, 1, 3, 7, 1);
        coll(4'b1000);
        coll(4'b0100);
        check_all("t5.over_hold", 5, 0, 1, 3, 7, 1);
        key[0] = 1'b0;
        frames(3);
        check_all("t5.idle", 0, 0, 1, 0, 7, 1);
        key[0] = 1'b1;
        frames(1);
        key[0] = 1'b0;
        frames(3);
        check_all("t5.restart", 1, 0, 1, 1, 0, 0);
        key[0] = 1'b1;
        frames(1);
        frames(59);
        check_vec("t6.play", 8'(game_state), 8'd2);

        // T6: asynchronous reset mid-play, checked before any clock edge
        @(negedge clk_25);
        #5 resetN = 1'b0;
        #1;
        check_all("t6.arst", 0, 0, 1, 0, 0, 0);
        @(negedge clk_25);
        resetN = 1'b1;
        @(negedge clk_25);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
